// File: rtl/button_step_ctrl.sv
// button_step_ctrl: synchronise and debounce three buttons, pulse once per clean press, keep wrapping step counters.
// Ports: CLOCK system clock; RESET synchronous active-high reset; btnU/btnC/btnD raw bouncing buttons;
//        step_clr clears all steps; press_u/press_c/press_d one-cycle accepted-press pulses;
//        stepU/stepC/stepD step counts (0..STEPS-1); all_match high while every step equals MATCH_STEP.
module button_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int STEPS = 5,
    parameter int MATCH_STEP = 3
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       btnU,
    input  logic       btnC,
    input  logic       btnD,
    input  logic       step_clr,
    output logic       press_u,
    output logic       press_c,
    output logic       press_d,
    output logic [2:0] stepU,
    output logic [2:0] stepC,
    output logic [2:0] stepD,
    output logic       all_match
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [2:0] STEP_MAX = 3'(STEPS - 1);
    localparam logic [2:0] MATCH = 3'(MATCH_STEP);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    logic [2:0] btn, press;
    logic [2:0][2:0] step;

    assign btn = {btnD, btnC, btnU};

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_btn
            logic s1, s2, fire, press_q;
            logic [2:0] step_q;
            logic [CW-1:0] cnt, cnt_n;
            state_t state, state_n;
            always_ff @(posedge CLOCK) begin
                if (RESET) begin
                    s1      <= 1'b0;
                    s2      <= 1'b0;
                    state   <= IDLE;
                    cnt     <= '0;
                    press_q <= 1'b0;
                    step_q  <= '0;
                end else begin
                    s1      <= btn[i];
                    s2      <= s1;
                    state   <= state_n;
                    cnt     <= cnt_n;
                    press_q <= fire;
                    // clear wins over a press landing on the same edge
                    step_q  <= step_clr ? 3'd0 : fire ? ((step_q == STEP_MAX) ? 3'd0 : step_q + 3'd1) : step_q;
                end
            end
            always_comb begin
                state_n = state;
                cnt_n   = cnt;
                fire    = 1'b0;
                case (state)
                    IDLE: if (s2) begin
                        state_n = PRESS_WAIT;
                        cnt_n   = CNT_ONE;
                    end
                    PRESS_WAIT: if (!s2) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_n = PRESSED;
                        fire    = 1'b1;
                    end else cnt_n = cnt + CNT_ONE;
                    PRESSED: if (!s2) begin
                        state_n = RELEASE_WAIT;
                        cnt_n   = CNT_ONE;
                    end
                    // a re-press while waiting out release bounce returns to PRESSED without a new pulse
                    RELEASE_WAIT: if (s2) state_n = PRESSED;
                    else if (cnt == CNT_MAX) state_n = IDLE;
                    else cnt_n = cnt + CNT_ONE;
                    default: state_n = IDLE;
                endcase
            end
            assign press[i] = press_q;
            assign step[i]  = step_q;
        end
    endgenerate

    assign press_u   = press[0];
    assign press_c   = press[1];
    assign press_d   = press[2];
    assign stepU     = step[0];
    assign stepC     = step[1];
    assign stepD     = step[2];
    assign all_match = (step[0] == MATCH) && (step[1] == MATCH) && (step[2] == MATCH);
endmodule

// File: tb/tb_button_step_ctrl.sv
// tb_button_step_ctrl: scoreboard bench for button_step_ctrl with DEBOUNCE_CYCLES=4, STEPS=5, MATCH_STEP=3.
module tb_button_step_ctrl;
    localparam int D = 4;
    localparam int LAT = D + 1;

    logic CLOCK, RESET, btnU, btnC, btnD, step_clr;
    logic press_u, press_c, press_d, all_match;
    logic [2:0] stepU, stepC, stepD;

    typedef struct packed {
        logic [1:0]  btn;
        logic [31:0] at;
        logic [2:0]  step;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t e, o;
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    button_step_ctrl #(.DEBOUNCE_CYCLES(D), .STEPS(5), .MATCH_STEP(3)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .btnU(btnU), .btnC(btnC), .btnD(btnD), .step_clr(step_clr),
        .press_u(press_u), .press_c(press_c), .press_d(press_d),
        .stepU(stepU), .stepC(stepC), .stepD(stepD), .all_match(all_match)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic tick();
        @(posedge CLOCK);
        cyc++;
        @(negedge CLOCK);
        if (press_u) obs_q.push_back('{2'd0, 32'(cyc), stepU});
        if (press_c) obs_q.push_back('{2'd1, 32'(cyc), stepC});
        if (press_d) obs_q.push_back('{2'd2, 32'(cyc), stepD});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        {btnD, btnC, btnU} = 3'b000;
        step_clr = 1'b0;
        ticks(2);
        RESET = 1'b0;
        tick();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic clean_press(input logic [2:0] mask, input logic [2:0] su, sc, sd, input int hi, lo);
        int t0;
        {btnD, btnC, btnU} = mask;
        t0 = cyc + 1;
        if (mask[0]) exp_q.push_back('{2'd0, 32'(t0 + LAT), su});
        if (mask[1]) exp_q.push_back('{2'd1, 32'(t0 + LAT), sc});
        if (mask[2]) exp_q.push_back('{2'd2, 32'(t0 + LAT), sd});
        ticks(hi);
        {btnD, btnC, btnU} = 3'b000;
        ticks(lo);
    endtask

    task automatic test_reset();
        int t0;
        RESET = 1'b1;
        step_clr = 1'b0;
        {btnD, btnC, btnU} = 3'b111;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if ({press_d, press_c, press_u, stepU, stepC, stepD, all_match} !== 13'b0) begin
                mismatched++;
                $display("FAIL reset_state: press=%b steps=%0d/%0d/%0d all_match=%b, required all zero",
                         {press_d, press_c, press_u}, stepU, stepC, stepD, all_match);
            end
        end
        obs_q.delete();
        RESET = 1'b0;
        t0 = cyc + 1;
        for (int b = 0; b < 3; b++) exp_q.push_back('{2'(b), 32'(t0 + LAT), 3'd1});
        ticks(12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("FAIL reset_press: no pulse, required btn %0d at edge %0d step %0d", e.btn, e.at, e.step);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("FAIL reset_press: got btn %0d edge %0d step %0d, required btn %0d edge %0d step %0d",
                             o.btn, o.at, o.step, e.btn, e.at, e.step);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL reset_extra: %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
        {btnD, btnC, btnU} = 3'b000;
        ticks(10);
    endtask

    task automatic test_single_press();
        int t0;
        do_reset();
        btnU = 1'b1;
        t0 = cyc + 1;
        exp_q.push_back('{2'd0, 32'(t0 + LAT), 3'd1});
        ticks(30);
        btnU = 1'b0;
        ticks(10);
        compared++;
        if ({stepU, stepC, stepD} !== {3'd1, 3'd0, 3'd0}) begin
            mismatched++;
            $display("FAIL single_steps: got %0d/%0d/%0d, required 1/0/0", stepU, stepC, stepD);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("FAIL single_press: no pulse, required btn %0d at edge %0d step %0d", e.btn, e.at, e.step);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("FAIL single_press: got btn %0d edge %0d step %0d, required btn %0d edge %0d step %0d",
                             o.btn, o.at, o.step, e.btn, e.at, e.step);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL single_extra: %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_glitch();
        do_reset();
        btnC = 1'b1;
        ticks(3);
        btnC = 1'b0;
        ticks(10);
        compared++;
        if (obs_q.size() != 0 || stepC !== 3'd0) begin
            mismatched++;
            $display("FAIL glitch: pulses %0d stepC %0d, required 0 pulses stepC 0", obs_q.size(), stepC);
            obs_q.delete();
        end
        clean_press(3'b010, 3'd0, 3'd1, 3'd0, 8, 12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("FAIL glitch_recover: no pulse, required btn %0d at edge %0d step %0d", e.btn, e.at, e.step);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("FAIL glitch_recover: got btn %0d edge %0d step %0d, required btn %0d edge %0d step %0d",
                             o.btn, o.at, o.step, e.btn, e.at, e.step);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL glitch_extra: %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_release_bounce();
        int t0;
        int durs[5] = '{2, 1, 3, 2, 10};
        do_reset();
        btnD = 1'b1;
        t0 = cyc + 1;
        exp_q.push_back('{2'd2, 32'(t0 + LAT), 3'd1});
        ticks(8);
        for (int k = 0; k < 5; k++) begin
            btnD = k[0];
            ticks(durs[k]);
        end
        compared++;
        if (stepD !== 3'd1) begin
            mismatched++;
            $display("FAIL bounce_step: stepD %0d, required 1", stepD);
        end
        clean_press(3'b100, 3'd0, 3'd0, 3'd2, 8, 12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("FAIL bounce_press: no pulse, required btn %0d at edge %0d step %0d", e.btn, e.at, e.step);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("FAIL bounce_press: got btn %0d edge %0d step %0d, required btn %0d edge %0d step %0d",
                             o.btn, o.at, o.step, e.btn, e.at, e.step);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL bounce_extra: %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_wrap();
        logic [2:0] seq[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        do_reset();
        for (int k = 0; k < 5; k++) clean_press(3'b100, 3'd0, 3'd0, seq[k], 8, 12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("FAIL wrap_press: no pulse, required btn %0d at edge %0d step %0d", e.btn, e.at, e.step);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("FAIL wrap_press: got btn %0d edge %0d step %0d, required btn %0d edge %0d step %0d",
                             o.btn, o.at, o.step, e.btn, e.at, e.step);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL wrap_extra: %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_match_and_clear();
        int t0;
        logic exp_m;
        do_reset();
        clean_press(3'b111, 3'd1, 3'd1, 3'd1, 8, 12);
        clean_press(3'b111, 3'd2, 3'd2, 3'd2, 8, 12);
        {btnD, btnC, btnU} = 3'b111;
        t0 = cyc + 1;
        for (int b = 0; b < 3; b++) exp_q.push_back('{2'(b), 32'(t0 + LAT), 3'd3});
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_m = (cyc >= t0 + LAT);
            compared++;
            if (all_match !== exp_m) begin
                mismatched++;
                $display("FAIL match_timing: edge %0d all_match %b, required %b", cyc, all_match, exp_m);
            end
        end
        {btnD, btnC, btnU} = 3'b000;
        ticks(12);
        clean_press(3'b001, 3'd4, 3'd0, 3'd0, 8, 12);
        compared++;
        if ({all_match, stepU, stepC, stepD} !== {1'b0, 3'd4, 3'd3, 3'd3}) begin
            mismatched++;
            $display("FAIL match_break: all_match %b steps %0d/%0d/%0d, required 0 4/3/3",
                     all_match, stepU, stepC, stepD);
        end
        btnC = 1'b1;
        t0 = cyc + 1;
        exp_q.push_back('{2'd1, 32'(t0 + LAT), 3'd0});
        for (int k = 0; k < 8; k++) begin
            step_clr = (cyc + 1 == t0 + LAT);
            tick();
        end
        step_clr = 1'b0;
        btnC = 1'b0;
        ticks(12);
        compared++;
        if ({all_match, stepU, stepC, stepD} !== 10'b0) begin
            mismatched++;
            $display("FAIL clear_steps: all_match %b steps %0d/%0d/%0d, required 0 0/0/0",
                     all_match, stepU, stepC, stepD);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_q.size() == 0) begin
                mismatched++;
                $display("FAIL match_press: no pulse, required btn %0d at edge %0d step %0d", e.btn, e.at, e.step);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    mismatched++;
                    $display("FAIL match_press: got btn %0d edge %0d step %0d, required btn %0d edge %0d step %0d",
                             o.btn, o.at, o.step, e.btn, e.at, e.step);
                end
            end
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL match_extra: %0d extra pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        RESET = 1'b1;
        step_clr = 1'b0;
        {btnD, btnC, btnU} = 3'b000;
        test_reset();
        test_single_press();
        test_glitch();
        test_release_bounce();
        test_wrap();
        test_match_and_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
